// File: rtl/sram_burst_scan_ctrl.sv
// Serial scan-to-SRAM burst controller: header, then write or read words; build with SCAN_PARITY_EN to add a per-word even-parity bit.
// One bit per qualified cycle; scan_en=0 stalls HDR/WSHIFT/RSHIFT; SRAM strobes are registered, read data is captured one cycle after RREQ.
module sram_burst_scan_ctrl #(
  parameter int N_ADDR = 11,
  parameter int N_DATA = 8,
  parameter int N_CNT  = 12
) (
  input  logic              clk_1,
  input  logic              rst_n_sync,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
  output logic              scan_out_vld,
  output logic              busy,
  output logic              done,
  output logic              sram_en,
  output logic              sram_we,
  output logic [N_ADDR-1:0] sram_addr,
  output logic [N_DATA-1:0] sram_din,
`ifdef SCAN_PARITY_EN
  input  logic [N_DATA-1:0] sram_dout,
  output logic              parity_err
`else
  input  logic [N_DATA-1:0] sram_dout
`endif
);

  localparam int HDR_W = N_ADDR + N_CNT + 1;
`ifdef SCAN_PARITY_EN
  localparam int WORD_W = N_DATA + 1;
`else
  localparam int WORD_W = N_DATA;
`endif
  localparam int MAX_B = (HDR_W > WORD_W) ? HDR_W : WORD_W;
  localparam int CNT_W = $clog2(MAX_B + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WSHIFT, WRITE, RREQ, RCAP, RSHIFT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [N_DATA-1:0] wsr_q, wsr_d;
  logic [N_DATA-1:0] rsr_q, rsr_d;
  logic [N_ADDR-1:0] addr_q, addr_d;
  logic [N_CNT-1:0]  rem_q, rem_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [N_ADDR-1:0] sram_addr_q, sram_addr_d;
  logic [N_DATA-1:0] sram_din_q, sram_din_d;
  logic              word_done;
`ifdef SCAN_PARITY_EN
  logic              rpar_q, rpar_d;
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hdr_d     = hdr_q;
    wsr_d     = wsr_q;
    rsr_d     = rsr_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    word_done = 1'b0;
`ifdef SCAN_PARITY_EN
    rpar_d    = rpar_q;
    perr_d    = perr_q;
`endif

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          hdr_d     = {scan_in, hdr_q[HDR_W-1:1]};
          bit_cnt_d = CNT_W'(1);
          state_d   = HDR;
        end
      end
      HDR: begin
        if (scan_en) begin
          // Header shifts in from the top so bit 0 lands at hdr[0] after the last bit.
          hdr_d = {scan_in, hdr_q[HDR_W-1:1]};
          if (bit_cnt_q == HDR_LAST) begin
            bit_cnt_d = '0;
            addr_d    = hdr_d[HDR_W-1 -: N_ADDR];
            rem_d     = hdr_d[N_CNT:1];
            state_d   = hdr_d[0] ? WSHIFT : RREQ;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      WSHIFT: begin
        if (scan_en) begin
          if (bit_cnt_q == WORD_LAST) begin
            bit_cnt_d = '0;
            state_d   = WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
`ifdef SCAN_PARITY_EN
          if (bit_cnt_q == WORD_LAST) begin
            if (scan_in != ^wsr_q) perr_d = 1'b1;
          end else begin
            wsr_d = {scan_in, wsr_q[N_DATA-1:1]};
          end
`else
          wsr_d = {scan_in, wsr_q[N_DATA-1:1]};
`endif
        end
      end
      WRITE:  word_done = 1'b1;
      RREQ:   state_d = RCAP;
      RCAP: begin
        rsr_d     = sram_dout;
        bit_cnt_d = '0;
        state_d   = RSHIFT;
`ifdef SCAN_PARITY_EN
        rpar_d    = ^sram_dout;
`endif
      end
      RSHIFT: begin
        if (scan_en) begin
          rsr_d = rsr_q >> 1;
          if (bit_cnt_q == WORD_LAST) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Remaining count is tested before decrement, so a full-scale count never wraps.
    if (word_done) begin
      addr_d = addr_q + N_ADDR'(1);
      if (rem_q == '0) begin
        state_d = DONE;
      end else begin
        rem_d   = rem_q - N_CNT'(1);
        state_d = (state_q == WRITE) ? WSHIFT : RREQ;
      end
    end

    sram_en_d   = (state_d == WRITE) || (state_d == RREQ);
    sram_we_d   = (state_d == WRITE);
    sram_addr_d = sram_en_d ? addr_d : sram_addr_q;
    sram_din_d  = sram_we_d ? wsr_d : sram_din_q;
  end

  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      wsr_q       <= '0;
      rsr_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      sram_en_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      wsr_q       <= wsr_d;
      rsr_q       <= rsr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      sram_en_q   <= sram_en_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rpar_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      rpar_q <= rpar_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
  assign scan_out   = scan_out_vld & ((bit_cnt_q == WORD_LAST) ? rpar_q : rsr_q[0]);
`else
  assign scan_out   = scan_out_vld & rsr_q[0];
`endif

  assign scan_out_vld = (state_q == RSHIFT) && scan_en;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign sram_en      = sram_en_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_din     = sram_din_q;

endmodule
